watermark_extractor: RTL and testbench
======================================

Name: watermark_extractor

Overview:
- Recovery-side counterpart of image_watermarking_system: reads a watermarked image from pixel memory and extracts the embedded bit plane.
- Packs the extracted bits into OUT_W-bit words and writes them to a watermark output memory.
- Uses the same start/done control handshake, so the existing bench style drives it unchanged.
- Sits between the watermarked-image RAM (dumped to watermarked_image.mem) and the recovered-watermark RAM.

Parameters:
- WM_W, 64: watermark width in bits (pixels).
- WM_H, 64: watermark height in bits (pixels). NPIX = WM_W*WM_H pixels are read in raster order from address 0.
- PIX_W, 8: pixel data width.
- BIT_POS, 0: bit plane extracted from each pixel; 0 <= BIT_POS < PIX_W.
- OUT_W, 8: packed output word width. NPIX must be a multiple of OUT_W; check at elaboration.
- ADDR_W, $clog2(NPIX): pixel address width.
- WADDR_W, $clog2(NPIX/OUT_W): watermark word address width.
- CNT_W, $clog2(NPIX+1): ones counter width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- pix_rd_en  out  1  pixel memory read enable
- pix_addr  out  ADDR_W  pixel read address
- pix_rdata  in  PIX_W  pixel data; valid the cycle after pix_rd_en (synchronous RAM)
- wm_we  out  1  watermark word write strobe
- wm_addr  out  WADDR_W  watermark word address
- wm_wdata  out  OUT_W  packed watermark word
- busy  out  1  high from accepted start until done rises
- done  out  1  level; high from completion until the next accepted start
- ones_count  out  CNT_W  number of extracted '1' bits; stable while done=1

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; pix_rd_en=0, pix_addr=0, wm_we=0, wm_addr=0, wm_wdata=0, busy=0, done=0, ones_count=0.
- Reset mid-run aborts immediately. There is no resume; the next start begins from address 0.
- States: IDLE -> READ -> DRAIN -> DONE -> IDLE(on start, else hold).
- IDLE / DONE:
  - start=1 at edge E: busy=1, done=0, pixel counter=0, ones_count=0, wm_addr counter=0, packer cleared; go to READ.
  - In DONE, start re-arms identically.
- READ:
  - pix_rd_en=1 every cycle; pix_addr = 0,1,...,NPIX-1 on consecutive cycles, with no gaps.
  - After issuing NPIX-1: go to DRAIN; pix_rd_en=0 and pix_addr holds its last value.
- Data path: a 1-cycle valid pipe tracks issued reads. On each valid cycle:
  - bit b = pix_rdata[BIT_POS] is shifted into the packer. The first bit of a word lands in wm_wdata[0] (LSB-first); the OUT_W-th bit lands in bit OUT_W-1.
  - ones_count increments by b.
- Write: on the edge that captures the OUT_W-th bit, register wm_wdata and assert wm_we for exactly one cycle at the current wm_addr. wm_addr increments on the following edge.
  - wm_addr after completion equals NPIX/OUT_W mod 2^WADDR_W.
  - The first write is at address 0.
- DRAIN: wait until the last word write has been issued, then go to DONE with busy=0 and done=1.
- Latency: start sampled at edge 0 -> last wm_we high in the cycle after edge NPIX+1 -> done high after edge NPIX+2.
  - Total NPIX+2 cycles; throughput is 1 pixel/cycle.
- start while busy is ignored, with no effect on the counters.
- Widths: ones_count saturation is impossible by construction (CNT_W sized for NPIX).
- pix_rdata bits other than BIT_POS are ignored.

Test Plan:
- Params WM_W=4, WM_H=4, OUT_W=8, BIT_POS=0; memory LSBs pattern 1,0,1,1,0,0,0,0, 1,1,1,1,1,1,1,1; pulse start
  -> wm_we at addr 0 data 8'h0D, addr 1 data 8'hFF
  -> ones_count=11; done rises exactly 18 cycles after start edge; busy high 18 cycles.
- Same run: check pix_addr sequence 0..15 contiguous, pix_rd_en high exactly 16 cycles, wm_we high exactly 2 cycles.
- BIT_POS=7, pixels alternate 8'h80 / 8'h7F -> words 8'h55, 8'h55; ones_count=8.
- Pulse start again at cycle 5 of an active run -> ignored, identical outputs. Then pulse start while done=1 -> done drops next cycle and the run repeats.
- Drop rst_n at pixel 9 -> all outputs zero asynchronously, no further wm_we. Then release and start -> full correct run from address 0.
- Default params (64x64) with random image vs golden LSB model
  -> 512 writes match the model, wm_addr wraps to 0, done after 4098 cycles.

Source files
------------

// File: rtl/watermark_extractor.sv
// Recovers one bit plane from a watermarked image held in synchronous pixel RAM and
// packs the bits LSB-first into OUT_W-bit words written to the watermark RAM.
module watermark_extractor #(
  parameter int unsigned WM_W    = 64,
  parameter int unsigned WM_H    = 64,
  parameter int unsigned PIX_W   = 8,
  parameter int unsigned BIT_POS = 0,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned ADDR_W  = $clog2(WM_W * WM_H),
  parameter int unsigned WADDR_W = $clog2(WM_W * WM_H / OUT_W),
  parameter int unsigned CNT_W   = $clog2(WM_W * WM_H + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               pix_rd_en,
  output logic [ADDR_W-1:0]  pix_addr,
  input  logic [PIX_W-1:0]   pix_rdata,
  output logic               wm_we,
  output logic [WADDR_W-1:0] wm_addr,
  output logic [OUT_W-1:0]   wm_wdata,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   ones_count
);

  localparam int unsigned NPIX   = WM_W * WM_H;
  localparam int unsigned BCNT_W = $clog2(OUT_W);

  if ((NPIX % OUT_W) != 0) begin : g_bad_out_w
    $error("NPIX must be a multiple of OUT_W");
  end
  if (BIT_POS >= PIX_W) begin : g_bad_bit_pos
    $error("BIT_POS must be below PIX_W");
  end
  if (OUT_W < 2) begin : g_bad_min_out_w
    $error("OUT_W must be at least 2");
  end

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  state_e             st_q, st_d;
  logic               accept, last_issue;
  logic               rd_en_q, valid_q, we_q, busy_q, done_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [OUT_W-1:0]   shreg_q, wdata_q, word_next;
  logic [BCNT_W-1:0]  bcnt_q;
  logic [CNT_W-1:0]   ones_q;
  logic [WADDR_W-1:0] waddr_q;
  logic               bit_in;

  // Masked reduction selects the bit plane while consuming the whole pixel word.
  assign bit_in    = |(pix_rdata & (PIX_W'(1) << BIT_POS));
  assign word_next = {bit_in, shreg_q[OUT_W-1:1]};

  always_comb begin
    st_d       = st_q;
    accept     = 1'b0;
    last_issue = 1'b0;
    unique case (st_q)
      StIdle, StDone: begin
        if (start) begin
          st_d   = StRead;
          accept = 1'b1;
        end
      end
      StRead: begin
        if (addr_q == ADDR_W'(NPIX - 1)) begin
          st_d       = StDrain;
          last_issue = 1'b1;
        end
      end
      StDrain: begin
        // The final pixel is captured once the read pipe empties.
        if (!valid_q) st_d = StDone;
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= StIdle;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      shreg_q <= '0;
      bcnt_q  <= '0;
      ones_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      st_q <= st_d;
      if (accept) begin
        rd_en_q <= 1'b1;
        addr_q  <= '0;
        valid_q <= 1'b0;
        shreg_q <= '0;
        bcnt_q  <= '0;
        ones_q  <= '0;
        we_q    <= 1'b0;
        waddr_q <= '0;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
      end else begin
        valid_q <= rd_en_q;
        we_q    <= 1'b0;
        if (st_q == StRead) begin
          if (last_issue) rd_en_q <= 1'b0;
          else            addr_q  <= addr_q + ADDR_W'(1);
        end
        if (we_q) waddr_q <= waddr_q + WADDR_W'(1);
        if (valid_q) begin
          shreg_q <= word_next;
          ones_q  <= ones_q + CNT_W'(bit_in);
          if (bcnt_q == BCNT_W'(OUT_W - 1)) begin
            wdata_q <= word_next;
            we_q    <= 1'b1;
            bcnt_q  <= '0;
          end else begin
            bcnt_q <= bcnt_q + BCNT_W'(1);
          end
        end
        if (st_q == StDrain && st_d == StDone) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign pix_rd_en  = rd_en_q;
  assign pix_addr   = addr_q;
  assign wm_we      = we_q;
  assign wm_addr    = waddr_q;
  assign wm_wdata   = wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign ones_count = ones_q;

endmodule

// File: tb/tb_watermark_extractor.sv
// Directed bench: three extractor instances (4x4 LSB, 4x4 bit 7, default 64x64) fed from
// behavioural synchronous RAMs; expected writes are queued when images are loaded.
module tb_watermark_extractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       s_start, s_rd_en, s_we, s_busy, s_done;
  logic [3:0] s_addr;
  logic [7:0] s_rdata, s_wdata;
  logic [0:0] s_waddr;
  logic [4:0] s_ones;

  logic       w_start, w_rd_en, w_we, w_busy, w_done;
  logic [3:0] w_addr;
  logic [7:0] w_rdata, w_wdata;
  logic [0:0] w_waddr;
  logic [4:0] w_ones;

  logic        b_start, b_rd_en, b_we, b_busy, b_done;
  logic [11:0] b_addr;
  logic [7:0]  b_rdata, b_wdata;
  logic [8:0]  b_waddr;
  logic [12:0] b_ones;

  watermark_extractor #(.WM_W(4), .WM_H(4), .BIT_POS(0)) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .pix_rd_en(s_rd_en), .pix_addr(s_addr),
    .pix_rdata(s_rdata), .wm_we(s_we), .wm_addr(s_waddr), .wm_wdata(s_wdata),
    .busy(s_busy), .done(s_done), .ones_count(s_ones)
  );

  watermark_extractor #(.WM_W(4), .WM_H(4), .BIT_POS(7)) u_b7 (
    .clk(clk), .rst_n(rst_n), .start(w_start), .pix_rd_en(w_rd_en), .pix_addr(w_addr),
    .pix_rdata(w_rdata), .wm_we(w_we), .wm_addr(w_waddr), .wm_wdata(w_wdata),
    .busy(w_busy), .done(w_done), .ones_count(w_ones)
  );

  watermark_extractor u_big (
    .clk(clk), .rst_n(rst_n), .start(b_start), .pix_rd_en(b_rd_en), .pix_addr(b_addr),
    .pix_rdata(b_rdata), .wm_we(b_we), .wm_addr(b_waddr), .wm_wdata(b_wdata),
    .busy(b_busy), .done(b_done), .ones_count(b_ones)
  );

  logic [7:0] s_mem [16];
  logic [7:0] w_mem [16];
  logic [7:0] b_mem [4096];

  always @(posedge clk) if (s_rd_en) s_rdata <= s_mem[s_addr];
  always @(posedge clk) if (w_rd_en) w_rdata <= w_mem[w_addr];
  always @(posedge clk) if (b_rd_en) b_rdata <= b_mem[b_addr];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [31:0] s_q[$], w_q[$], b_q[$];
  int s_nexp, s_rd, s_we_n, s_busy_n;

  always @(negedge clk) begin
    logic [31:0] e;
    if (s_rd_en) begin
      check("s_pix_addr", 64'(s_addr), 64'(s_nexp));
      s_nexp++;
      s_rd++;
    end
    if (s_busy) s_busy_n++;
    if (s_we) begin
      s_we_n++;
      if (s_q.size() == 0) check("s_unexpected_we", 64'(s_we), 64'd0);
      else begin
        e = s_q.pop_front();
        check("s_write", 64'({s_waddr, s_wdata}), 64'(e));
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] e;
    if (w_we) begin
      if (w_q.size() == 0) check("w_unexpected_we", 64'(w_we), 64'd0);
      else begin
        e = w_q.pop_front();
        check("w_write", 64'({w_waddr, w_wdata}), 64'(e));
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] e;
    if (b_we) begin
      if (b_q.size() == 0) check("b_unexpected_we", 64'(b_we), 64'd0);
      else begin
        e = b_q.pop_front();
        check("b_write", 64'({b_waddr, b_wdata}), 64'(e));
      end
    end
  end

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0:       s_start = v;
      1:       w_start = v;
      default: b_start = v;
    endcase
  endtask

  function automatic logic done_of(input int sel);
    case (sel)
      0:       return s_done;
      1:       return w_done;
      default: return b_done;
    endcase
  endfunction

  function automatic logic busy_of(input int sel);
    case (sel)
      0:       return s_busy;
      1:       return w_busy;
      default: return b_busy;
    endcase
  endfunction

  // Pulses start on instance sel and counts edges from the start edge until done is seen.
  task automatic run(input int sel, input int exp_cyc, input int restart_at, input string tag);
    int cnt = 0;
    @(negedge clk);
    s_nexp = 0; s_rd = 0; s_we_n = 0; s_busy_n = 0;
    set_start(sel, 1'b1);
    @(posedge clk); #1;
    set_start(sel, 1'b0);
    check({tag, "_busy_rise"}, 64'(busy_of(sel)), 64'd1);
    check({tag, "_done_drop"}, 64'(done_of(sel)), 64'd0);
    while (done_of(sel) !== 1'b1 && cnt < 6000) begin
      @(posedge clk); #1;
      cnt++;
      set_start(sel, cnt == restart_at);
    end
    set_start(sel, 1'b0);
    check({tag, "_latency"}, 64'(cnt), 64'(exp_cyc));
    check({tag, "_busy_end"}, 64'(busy_of(sel)), 64'd0);
  endtask

  task automatic small_checks(input string tag);
    check({tag, "_ones"}, 64'(s_ones), 64'd11);
    check({tag, "_rd_cycles"}, 64'(s_rd), 64'd16);
    check({tag, "_we_cycles"}, 64'(s_we_n), 64'd2);
    check({tag, "_busy_cycles"}, 64'(s_busy_n), 64'd18);
    check({tag, "_addr_hold"}, 64'({s_rd_en, s_addr}), 64'h0F);
    check({tag, "_wm_addr_wrap"}, 64'(s_waddr), 64'd0);
    check({tag, "_sb_empty"}, 64'(s_q.size()), 64'd0);
  endtask

  task automatic push_small();
    s_q.push_back(32'h00D);
    s_q.push_back(32'h1FF);
  endtask

  initial begin
    logic [15:0] pat;
    logic [31:0] r;
    logic [7:0]  word;
    int          ones, cnt;

    rst_n = 1'b0;
    s_start = 1'b0; w_start = 1'b0; b_start = 1'b0;
    s_nexp = 0; s_rd = 0; s_we_n = 0; s_busy_n = 0;

    pat = 16'hFF0D;
    for (int i = 0; i < 16; i++) begin
      r = $urandom();
      s_mem[i] = {r[7:1], pat[i]};
      w_mem[i] = (i % 2 == 0) ? 8'h80 : 8'h7F;
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_addr", 64'({s_rd_en, s_addr}), 64'd0);
    check("rst_we_wm", 64'({s_we, s_waddr, s_wdata}), 64'd0);
    check("rst_busy_done", 64'({s_busy, s_done, b_busy, b_done}), 64'd0);
    check("rst_ones", 64'(s_ones), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    push_small();
    run(0, 18, -1, "basic");
    small_checks("basic");

    push_small();
    run(0, 18, 5, "ignored_start");
    small_checks("ignored_start");

    push_small();
    run(0, 18, -1, "restart_done");
    small_checks("restart_done");

    w_q.push_back(32'h055);
    w_q.push_back(32'h155);
    run(1, 18, -1, "bitpos7");
    check("bitpos7_ones", 64'(w_ones), 64'd8);
    check("bitpos7_sb_empty", 64'(w_q.size()), 64'd0);

    // Abort mid-run: no expectations queued, so any write afterwards is flagged.
    @(negedge clk);
    s_nexp = 0;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    cnt = 0;
    while (!(s_rd_en === 1'b1 && s_addr === 4'd9) && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("abort_reach_pix9", 64'(s_addr), 64'd9);
    #1 rst_n = 1'b0;
    #1;
    check("abort_rd_addr", 64'({s_rd_en, s_addr}), 64'd0);
    check("abort_we_wm", 64'({s_we, s_waddr, s_wdata}), 64'd0);
    check("abort_busy_done_ones", 64'({s_busy, s_done, s_ones}), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    push_small();
    run(0, 18, -1, "after_abort");
    small_checks("after_abort");

    ones = 0;
    for (int w = 0; w < 512; w++) begin
      for (int j = 0; j < 8; j++) begin
        r = $urandom();
        b_mem[w*8 + j] = r[7:0];
        word[j] = r[0];
        ones += int'(r[0]);
      end
      b_q.push_back({15'd0, 9'(w), word});
    end
    run(2, 4098, -1, "big");
    check("big_ones", 64'(b_ones), 64'(ones));
    check("big_wm_addr_wrap", 64'(b_waddr), 64'd0);
    check("big_sb_empty", 64'(b_q.size()), 64'd0);
    check("big_rd_idle", 64'({b_rd_en, b_we}), 64'd0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
